// File: rtl/tdm_demultiplexer4x1.sv
// ---------------------------------------------------------------------------
// tdm_demultiplexer4x1
//
// Receive side of a 4-slot time-division link. Serial beats arrive one
// channel at a time in slot order 0,1,2,3; this block frames on the sync
// marker, collects slots 0..2 in a shadow register and, when the slot 3 beat
// arrives, loads the complete 4-channel word onto w with a one-cycle
// w_valid pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   din        channel sample of the current beat (DATA_WIDTH bits)
//   din_valid  din carries a beat this cycle
//   sync       current valid beat is slot 0
//   flush      synchronous abort back to HUNT (wins over a same-cycle beat)
//   w          reconstructed word, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   w_valid    one-cycle pulse, w has just been loaded with a new frame
//   slot       index of the next expected slot
//   locked     high while framed (LOCKED state)
//   sync_err   one-cycle pulse, sync seen at a nonzero slot while LOCKED
// ---------------------------------------------------------------------------
module tdm_demultiplexer4x1 #(
    parameter int DATA_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    din_valid,
    input  logic                    sync,
    input  logic                    flush,
    output logic [4*DATA_WIDTH-1:0] w,
    output logic                    w_valid,
    output logic [1:0]              slot,
    output logic                    locked,
    output logic                    sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state;

    // Only slots 0..2 need storage; the slot 3 beat goes straight into w.
    logic [DATA_WIDTH-1:0] shadow [3];

    // locked is a direct decode of the state flop, so it is registered.
    assign locked = (state == LOCKED);

    // Framing state machine plus the word assembly datapath. w_valid and
    // sync_err default low every cycle so they can only ever be one-cycle
    // pulses. flush is checked first so a beat arriving in the same cycle is
    // dropped without raising sync_err. In the misaligned-sync case the
    // stale shadow slots 1..2 are left in place: they are rewritten by the
    // new frame before slot 3 can complete, so they never reach w.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            slot     <= 2'd0;
            w        <= '0;
            w_valid  <= 1'b0;
            sync_err <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            w_valid  <= 1'b0;
            sync_err <= 1'b0;
            if (flush) begin
                state <= HUNT;
                slot  <= 2'd0;
            end else if (din_valid) begin
                case (state)
                    HUNT: begin
                        if (sync) begin
                            shadow[0] <= din;
                            slot      <= 2'd1;
                            state     <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (sync && (slot != 2'd0)) begin
                            sync_err  <= 1'b1;
                            shadow[0] <= din;
                            slot      <= 2'd1;
                        end else begin
                            case (slot)
                                2'd0: shadow[0] <= din;
                                2'd1: shadow[1] <= din;
                                2'd2: shadow[2] <= din;
                                default: begin
                                    w       <= {din, shadow[2], shadow[1], shadow[0]};
                                    w_valid <= 1'b1;
                                end
                            endcase
                            slot <= slot + 2'd1;
                        end
                    end
                    default: begin
                        state <= HUNT;
                        slot  <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demultiplexer4x1.sv
// ---------------------------------------------------------------------------
// tb_tdm_demultiplexer4x1
//
// Scoreboard bench for tdm_demultiplexer4x1. The stimulus process feeds
// beats into a frame-level reference model (a locked flag plus a queue of
// samples received in the current frame); every completed frame pushes its
// expected word into a scoreboard queue. A separate monitor on the falling
// edge pops and compares whenever the DUT raises w_valid, and otherwise
// checks that w is holding. Directed scenarios come first, then random.
// ---------------------------------------------------------------------------
module tb_tdm_demultiplexer4x1;

    localparam int DW = 1;

    logic            clk;
    logic            rst_n;
    logic [DW-1:0]   din;
    logic            din_valid;
    logic            sync;
    logic            flush;
    logic [4*DW-1:0] w;
    logic            w_valid;
    logic [1:0]      slot;
    logic            locked;
    logic            sync_err;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit              mdl_locked;
    bit              mdl_err;
    logic [DW-1:0]   mdl_frame[$];
    logic [4*DW-1:0] exp_q[$];
    logic [4*DW-1:0] mdl_w;

    tdm_demultiplexer4x1 #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .sync      (sync),
        .flush     (flush),
        .w         (w),
        .w_valid   (w_valid),
        .slot      (slot),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void checkValue(input string name, input logic [31:0] act,
                                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Frame-level behaviour: a frame is the list of samples since slot 0.
    function automatic void modelBeat(input bit v, input bit s, input logic [DW-1:0] d,
                                      input bit f);
        logic [4*DW-1:0] word;
        mdl_err = 1'b0;
        if (f) begin
            mdl_locked = 1'b0;
            mdl_frame.delete();
        end else if (v) begin
            if (!mdl_locked) begin
                if (s) begin
                    mdl_frame.delete();
                    mdl_frame.push_back(d);
                    mdl_locked = 1'b1;
                end
            end else if (s && mdl_frame.size() != 0) begin
                mdl_err = 1'b1;
                mdl_frame.delete();
                mdl_frame.push_back(d);
            end else begin
                mdl_frame.push_back(d);
                if (mdl_frame.size() == 4) begin
                    word = '0;
                    for (int k = 0; k < 4; k++) begin
                        word[k*DW +: DW] = mdl_frame[k];
                    end
                    exp_q.push_back(word);
                    mdl_frame.delete();
                end
            end
        end
    endfunction

    function automatic void modelReset();
        mdl_locked = 1'b0;
        mdl_err    = 1'b0;
        mdl_frame.delete();
        exp_q.delete();
        mdl_w      = '0;
    endfunction

    task automatic checkOutput();
        checkValue("slot", 32'(slot), 32'(mdl_frame.size() % 4));
        checkValue("locked", 32'(locked), 32'(mdl_locked));
        checkValue("sync_err", 32'(sync_err), 32'(mdl_err));
    endtask

    // One clock of stimulus; outputs checked 2 time units after the edge.
    task automatic applyStimulus(input bit v, input bit s, input logic [DW-1:0] d,
                                 input bit f);
        din       = d;
        din_valid = v;
        sync      = s;
        flush     = f;
        @(posedge clk);
        modelBeat(v, s, d, f);
        #2;
        checkOutput();
        din_valid = 1'b0;
        sync      = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic sendFrame(input logic [3:0] bits, input int gap);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, k == 0, bits[k], 1'b0);
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear
    // before any further clock edge.
    task automatic asyncReset();
        #1;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkValue("rst_w", 32'(w), 32'h0);
        checkValue("rst_w_valid", 32'(w_valid), 32'h0);
        checkValue("rst_slot", 32'(slot), 32'h0);
        checkValue("rst_locked", 32'(locked), 32'h0);
        checkValue("rst_sync_err", 32'(sync_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: pops an expected word on every w_valid pulse and
    // checks that w holds its last delivered value otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (w_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL w_valid_unexpected: got w=%0h expected no frame at %0t",
                             w, $time);
                end else begin
                    mdl_w = exp_q.pop_front();
                    if (w !== mdl_w) begin
                        errors++;
                        $display("[TB] FAIL word: got %0h expected %0h at %0t", w, mdl_w, $time);
                    end
                end
            end else begin
                checks++;
                if (w !== mdl_w) begin
                    errors++;
                    $display("[TB] FAIL w_hold: got %0h expected %0h at %0t", w, mdl_w, $time);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        sync      = 1'b0;
        flush     = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset and idle.
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkValue("idle_w", 32'(w), 32'h0);
        checkValue("idle_w_valid", 32'(w_valid), 32'h0);

        // Frame assembly, back to back.
        sendFrame(4'b1101, 0);
        checkValue("frame1_w", 32'(w), 32'hD);
        checkValue("frame1_w_valid", 32'(w_valid), 32'h1);
        sendFrame(4'b0010, 0);
        checkValue("frame2_w", 32'(w), 32'h2);

        // Gapped beats.
        sendFrame(4'b1101, 2);

        // Hunt discard after a flush.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        sendFrame(4'b1000, 0);
        checkValue("hunt_w", 32'(w), 32'h8);

        // Misalignment: sync on slot 2 restarts the frame at slot 0.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkValue("mis_sync_err", 32'(sync_err), 32'h1);
        checkValue("mis_slot", 32'(slot), 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkValue("mis_w", 32'(w), 32'hE);

        // flush mid-frame, with a beat in the same cycle.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkValue("flush_w", 32'(w), 32'hE);

        // Async reset mid-frame.
        sendFrame(4'b0110, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        asyncReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);

        // Randomised traffic with flywheel slots, misaligned syncs, flushes
        // and occasional resets.
        for (int n = 0; n < 600; n++) begin
            bit v;
            bit s;
            bit f;
            v = ($urandom_range(0, 3) != 0);
            if (mdl_frame.size() == 0) begin
                s = ($urandom_range(0, 9) != 0);
            end else begin
                s = ($urandom_range(0, 19) == 0);
            end
            f = ($urandom_range(0, 49) == 0);
            applyStimulus(v, s, DW'($urandom), f);
            if ($urandom_range(0, 199) == 0 && mdl_frame.size() != 0) begin
                asyncReset();
            end
        end

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkValue("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
